// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for the shared execute-stage ALU: two requesters,
// one registered response slot and the condition-code output.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_fun;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_set_cc;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_fun;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_set_cc;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_valE;
    logic [2:0]       cc;

    modport master (
        output req0_valid, req0_fun, req0_a, req0_b, req0_set_cc,
        output req1_valid, req1_fun, req1_a, req1_b, req1_set_cc,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_valE, cc
    );

    modport slave (
        input  req0_valid, req0_fun, req0_a, req0_b, req0_set_cc,
        input  req1_valid, req1_fun, req1_a, req1_b, req1_set_cc,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_valE, cc
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// One 64-bit add/sub/and/xor ALU shared by two requesters with round-robin
// (or fixed) arbitration, a single registered response slot and Y86 {ZF,SF,OF}.
module alu_share_arbiter #(
    parameter int WIDTH     = 64,
    parameter int RR_ENABLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus
);
    localparam logic [1:0] FUN_ADD = 2'b00;
    localparam logic [1:0] FUN_SUB = 2'b01;
    localparam logic [1:0] FUN_AND = 2'b10;

    function automatic logic [WIDTH-1:0] alu_result(
        input logic [1:0]              fun,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] r;
        case (fun)
            FUN_ADD: r = a + b;
            FUN_SUB: r = a - b;
            FUN_AND: r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Overflow only exists for add/sub; logic ops always clear OF.
    function automatic logic [2:0] alu_flags(
        input logic [1:0]              fun,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic signed [WIDTH-1:0] r
    );
        logic of;
        case (fun)
            FUN_ADD: of = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            FUN_SUB: of = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: of = 1'b0;
        endcase
        return {(r == '0), r[WIDTH-1], of};
    endfunction

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_valE_q, rsp_valE_d;
    logic [2:0]       cc_q, cc_d;
    logic             last_q, last_d;

    logic             slot_free;
    logic             grant0, grant1;
    logic             ready0, ready1;
    logic             xfer;
    logic             sel_id;
    logic [1:0]       sel_fun;
    logic signed [WIDTH-1:0] sel_a, sel_b;
    logic             sel_set_cc;
    logic [WIDTH-1:0] alu_r;

    // last_q = 1 means requester 1 won most recently, so requester 0 wins a tie.
    always_comb begin
        slot_free = !rsp_valid_q || bus.rsp_ready;
        grant1    = bus.req1_valid &&
                    (!bus.req0_valid || ((RR_ENABLE != 0) && !last_q));
        grant0    = bus.req0_valid && !grant1;
        ready0    = grant0 && slot_free && !reset;
        ready1    = grant1 && slot_free && !reset;
        xfer      = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
    end

    always_comb begin
        sel_id     = grant1;
        sel_fun    = bus.req0_fun;
        sel_a      = bus.req0_a;
        sel_b      = bus.req0_b;
        sel_set_cc = bus.req0_set_cc;
        if (grant1) begin
            sel_fun    = bus.req1_fun;
            sel_a      = bus.req1_a;
            sel_b      = bus.req1_b;
            sel_set_cc = bus.req1_set_cc;
        end
        alu_r = alu_result(sel_fun, sel_a, sel_b);
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_valE_d  = rsp_valE_q;
        cc_d        = cc_q;
        last_d      = last_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = sel_id;
            rsp_valE_d  = alu_r;
            last_d      = sel_id;
            if (sel_set_cc) begin
                cc_d = alu_flags(sel_fun, sel_a, sel_b, alu_r);
            end
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response slot register boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_valE_q  <= '0;
            cc_q        <= 3'b100;
            last_q      <= 1'b1;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valE_q  <= rsp_valE_d;
            cc_q        <= cc_d;
            last_q      <= last_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_valE   = rsp_valE_q;
    assign bus.cc         = cc_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter, compared against a
// transaction-level model of the shared ALU, response slot and flags.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        v0, v1, sc0, sc1, rr;
    logic [1:0]  f0, f1;
    logic [63:0] a0, b0, a1, b1;

    alu_share_arbiter_if #(.WIDTH(64)) ifc ();
    alu_share_arbiter_if #(.WIDTH(64)) ifp ();

    assign ifc.req0_valid = v0;  assign ifp.req0_valid = v0;
    assign ifc.req0_fun = f0;    assign ifp.req0_fun = f0;
    assign ifc.req0_a = a0;      assign ifp.req0_a = a0;
    assign ifc.req0_b = b0;      assign ifp.req0_b = b0;
    assign ifc.req0_set_cc = sc0; assign ifp.req0_set_cc = sc0;
    assign ifc.req1_valid = v1;  assign ifp.req1_valid = v1;
    assign ifc.req1_fun = f1;    assign ifp.req1_fun = f1;
    assign ifc.req1_a = a1;      assign ifp.req1_a = a1;
    assign ifc.req1_b = b1;      assign ifp.req1_b = b1;
    assign ifc.req1_set_cc = sc1; assign ifp.req1_set_cc = sc1;
    assign ifc.rsp_ready = rr;   assign ifp.rsp_ready = rr;

    alu_share_arbiter #(.WIDTH(64), .RR_ENABLE(1)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave));
    alu_share_arbiter #(.WIDTH(64), .RR_ENABLE(0)) dut_fp (
        .clk(clk), .reset(reset), .bus(ifp.slave));

    int checks = 0;
    int errors = 0;

    // Reference state: contents of the response slot and who wins the next tie.
    logic        m_valid;
    logic        m_id;
    logic [63:0] m_val;
    logic [2:0]  m_cc;
    int          m_tie;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Flags derived from exact integer arithmetic on sign-extended operands.
    task automatic ref_alu(input logic [1:0] fun, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] res, output logic [2:0] fl);
        logic signed [64:0] wide;
        logic of;
        wide = '0;
        of = 1'b0;
        case (fun)
            2'd0: begin res = a + b; wide = $signed({a[63], a}) + $signed({b[63], b}); of = wide[64] != wide[63]; end
            2'd1: begin res = a - b; wide = $signed({a[63], a}) - $signed({b[63], b}); of = wide[64] != wide[63]; end
            2'd2: res = a & b;
            default: res = a ^ b;
        endcase
        fl = {res == 64'd0, res[63], of};
    endtask

    task automatic cycle();
        logic slot_free, e0, e1;
        int win;
        logic [63:0] r;
        logic [2:0] fl;
        #1;
        slot_free = !m_valid || rr;
        win = (v0 && v1) ? m_tie : (v1 ? 1 : 0);
        e0 = !reset && slot_free && v0 && (win == 0);
        e1 = !reset && slot_free && v1 && (win == 1);
        chk("req0_ready", ifc.req0_ready, e0);
        chk("req1_ready", ifc.req1_ready, e1);
        chk("rsp_valid", ifc.rsp_valid, m_valid);
        chk("rsp_id", ifc.rsp_id, m_id);
        chk("rsp_valE", ifc.rsp_valE, m_val);
        chk("cc", ifc.cc, m_cc);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_id = 0; m_val = 0; m_cc = 3'b100; m_tie = 0;
        end else if (e0 || e1) begin
            if (e1) begin
                ref_alu(f1, a1, b1, r, fl);
                if (sc1) m_cc = fl;
            end else begin
                ref_alu(f0, a0, b0, r, fl);
                if (sc0) m_cc = fl;
            end
            m_valid = 1; m_id = e1; m_val = r; m_tie = e1 ? 0 : 1;
        end else if (m_valid && rr) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [1:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic s);
        v0 = v; f0 = f; a0 = a; b0 = b; sc0 = s;
    endtask

    task automatic set1(input logic v, input logic [1:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic s);
        v1 = v; f1 = f; a1 = a; b1 = b; sc1 = s;
    endtask

    task automatic rand_req(input int n);
        logic [1:0] f;
        logic [63:0] a, b;
        f = 2'($urandom_range(0, 3));
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
        if (n == 0) set0(1'b1, f, a, b, 1'($urandom_range(0, 1)));
        else        set1(1'b1, f, a, b, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        m_valid = 0; m_id = 0; m_val = 0; m_cc = 3'b100; m_tie = 0;
        reset = 1; rr = 1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        cycle();
        cycle();
        reset = 0;

        // First add: ready same cycle, result and flags one cycle later.
        set0(1, 2'd0, 64'h17, 64'h25, 1);
        #1 chk("first_ready", ifc.req0_ready, 1'b1);
        chk("cc_before", ifc.cc, 3'b100);
        cycle();
        set0(0, 0, 0, 0, 0);
        chk("first_val", ifc.rsp_valE, 64'h3C);
        chk("first_cc", ifc.cc, 3'b000);
        cycle();

        // Both requesters valid: round-robin alternates from 0, fixed priority stays on 0.
        reset = 1;
        cycle();
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            rand_req(0);
            rand_req(1);
            #1 chk("rr_grant0", ifc.req0_ready, (i % 2) == 0);
            chk("fp_grant0", ifp.req0_ready, 1'b1);
            chk("fp_grant1", ifp.req1_ready, 1'b0);
            cycle();
        end

        // Backpressure with both valid, then drain-and-reload.
        rr = 0;
        for (int i = 0; i < 3; i++) begin
            rand_req(0);
            rand_req(1);
            cycle();
        end
        rr = 1;
        cycle();
        chk("reload_valid", ifc.rsp_valid, 1'b1);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        cycle();

        // Flag corner cases.
        set0(1, 2'd1, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 1);
        cycle();
        chk("sub_val", ifc.rsp_valE, 64'h8000_0000_0000_0000);
        chk("sub_cc", ifc.cc, 3'b011);
        set0(1, 2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1);
        cycle();
        chk("add_val", ifc.rsp_valE, 64'h0);
        chk("add_cc", ifc.cc, 3'b101);
        set0(1, 2'd1, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 1);
        cycle();
        set1(1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        set0(0, 0, 0, 0, 0);
        cycle();
        chk("xor_val", ifc.rsp_valE, 64'h0);
        chk("xor_cc_hold", ifc.cc, 3'b011);
        set1(0, 0, 0, 0, 0);

        // Reset while a response is pending and requester 1 is waiting.
        rr = 0;
        cycle();
        set1(1, 2'd0, 64'h5, 64'h6, 1);
        reset = 1;
        #1 chk("rst_ready1", ifc.req1_ready, 1'b0);
        cycle();
        reset = 0;
        chk("rst_valid", ifc.rsp_valid, 1'b0);
        chk("rst_val", ifc.rsp_valE, 64'h0);
        chk("rst_cc", ifc.cc, 3'b100);
        rr = 1;
        set0(1, 2'd2, 64'hF0, 64'h3C, 1);
        #1 chk("rst_tie", ifc.req0_ready, 1'b1);
        cycle();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) rand_req(0); else set0(0, 0, 0, 0, 0);
            if ($urandom_range(0, 1) == 1) rand_req(1); else set1(0, 0, 0, 0, 0);
            rr = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 0;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 64-bit ALU (add/sub/and/xor) between two requesters using valid/ready handshakes and round-robin arbitration.
- Registers the ALU result into a single response slot with backpressure.
- Holds the Y86 condition-code register (ZF, SF, OF). Each request chooses whether it updates the codes.
- Sits in the execute stage. Requester 0 is the main pipeline execute path; requester 1 is an auxiliary multi-cycle unit.

Parameters:
WIDTH, 64, datapath width of operands and result
RR_ENABLE, 1, 1 = round-robin arbitration; 0 = fixed priority to requester 0

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation is accepted this cycle
req0_fun  input  2  ALU function: 00 add, 01 sub (A-B), 10 and, 11 xor
req0_a  input  WIDTH  operand A
req0_b  input  WIDTH  operand B
req0_set_cc  input  1  update the condition codes with this result
req1_valid, req1_ready, req1_fun, req1_a, req1_b, req1_set_cc: same directions and widths as requester 0
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  consumer takes the result this cycle
rsp_id  output  1  index of the requester that owns the result
rsp_valE  output  WIDTH  registered ALU result
cc  output  3  condition codes {ZF, SF, OF}

Behaviour:
- Reset (synchronous, highest priority):
  - rsp_valid=0, rsp_id=0, rsp_valE=0, cc=3'b100.
  - Round-robin pointer set so requester 0 wins the next tie.
  - A pending response is discarded. No cc update happens in the reset cycle.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant selection:
  - If only one requester is valid, it gets the grant.
  - If both are valid and RR_ENABLE=1, grant goes to the requester not granted last.
  - If both are valid and RR_ENABLE=0, requester 0 always wins.
- Ready signals:
  - reqN_ready = grantN && slot_free && !reset. They are combinational.
  - At most one reqN_ready is high in any cycle.
  - reqN_ready may depend on either reqN_valid. Requesters must not drive valid from ready.
- Transfer: occurs when reqN_valid && reqN_ready. At that rising edge:
  - rsp_valE and rsp_id are loaded and rsp_valid is set to 1.
  - The round-robin pointer records N. The pointer changes only on a transfer.
- Latency and throughput:
  - The result is visible exactly 1 cycle after acceptance.
  - Throughput is one operation per cycle when rsp_ready is held high.
- Response consumption:
  - If rsp_valid && rsp_ready and no transfer occurs, rsp_valid clears.
  - Accept and drain in the same cycle: the slot reloads and rsp_valid stays 1.
- Backpressure: while rsp_valid && !rsp_ready, rsp_valE, rsp_id and cc hold stable and both readies are 0.
- Arithmetic:
  - All operations are modulo 2^WIDTH, two's complement.
  - sub computes A - B.
- Condition codes: cc updates at the transfer edge only if the accepted request has set_cc=1. Otherwise cc holds.
  - ZF = (result == 0).
  - SF = result[WIDTH-1].
  - OF for add: A[msb]==B[msb] && result[msb]!=A[msb].
  - OF for sub: A[msb]!=B[msb] && result[msb]!=A[msb].
  - OF for and/xor: 0.
- Operands and fun are sampled only at the transfer edge. Their values at other times are ignored.
- A requester may deassert valid without a transfer. No state changes.

Test Plan:
- Reset, then req0_valid=1 add 0x17+0x25 set_cc=1, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_valE=0x3C, cc=000. Before the transfer cc=100.
- Both requesters valid continuously, rsp_ready=1, RR_ENABLE=1 -> grants alternate 0,1,0,1 starting with 0; rsp_id follows one cycle later. With RR_ENABLE=0, grants are always 0.
- Backpressure: result pending, rsp_ready=0 for 3 cycles with both requesters valid -> rsp_valE, rsp_id and cc stable, both readies 0. In the cycle rsp_ready=1, a new transfer occurs and rsp_valid stays 1 with the new result.
- Flags:
  - sub 0x4000_0000_0000_0000 - 0xC000_0000_0000_0000 -> rsp_valE=0x8000_0000_0000_0000, cc=011.
  - add 0x8000_0000_0000_0000 + 0x8000_0000_0000_0000 -> rsp_valE=0, cc=101.
- set_cc gating: xor 0xFFFF_FFFF_FFFF_FFFF ^ 0xFFFF_FFFF_FFFF_FFFF with set_cc=0 after cc=011 -> rsp_valE=0, cc stays 011.
- Reset asserted while rsp_valid=1 and rsp_ready=0 with req1 valid -> req1_ready=0 that cycle; next cycle rsp_valid=0, rsp_valE=0, cc=100. The next tie is granted to requester 0.
